// File: rtl/mhd_pkg.sv
// Shared types and helpers for the Hamming-distance error monitor:
// FSM state encoding, population count and saturating increment.
package mhd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Helpers operate on a wide container so any OUT_W/CNT_W up to 64 fits.
   localparam int unsigned MAX_W = 64;
   typedef logic [MAX_W-1:0] wide_t;

   function automatic int unsigned f_popcount(input wide_t v, input int unsigned w);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if ((i < w) && v[i]) n++;
      end
      return n;
   endfunction

   // Increment that sticks at the all-ones value of a w-bit counter.
   function automatic wide_t f_sat_inc(input wide_t v, input int unsigned w);
      wide_t lim;
      lim = (w >= MAX_W) ? '1 : ((wide_t'(1) << w) - wide_t'(1));
      return (v >= lim) ? lim : (v + wide_t'(1));
   endfunction

endpackage

// File: rtl/mhd_error_monitor_if.sv
// Valid/ready channel carrying one exact/approximate output pair per transfer.
interface mhd_error_monitor_if #(
   parameter int unsigned OUT_W = 5
) ();

   logic             in_valid;
   logic             in_ready;
   logic [OUT_W-1:0] exact_po;
   logic [OUT_W-1:0] approx_po;

   modport master (output in_valid, exact_po, approx_po, input in_ready);
   modport slave  (input in_valid, exact_po, approx_po, output in_ready);

endinterface

// File: rtl/mhd_bit_counter.sv
// Saturating up-counter with synchronous clear, used for per-bit mismatch counts.
module mhd_bit_counter
   import mhd_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= CNT_W'(f_sat_inc(wide_t'(count), CNT_W));
      end
   end

endmodule

// File: rtl/mhd_error_monitor.sv
// Accumulates Hamming-distance statistics between exact and approximate
// partition outputs over a programmed number of samples.
module mhd_error_monitor
   import mhd_pkg::*;
#(
   parameter  int unsigned OUT_W = 5,
   parameter  int unsigned CNT_W = 16,
   localparam int unsigned HD_W  = $clog2(OUT_W + 1),
   localparam int unsigned ACC_W = CNT_W + HD_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [CNT_W-1:0]       num_samples,
   mhd_error_monitor_if.slave     pair_if,
   output logic                   busy,
   output logic                   done,
   output logic [ACC_W-1:0]       hd_sum,
   output logic [CNT_W-1:0]       err_samples,
   output logic [HD_W-1:0]        max_hd,
   output logic [OUT_W*CNT_W-1:0] bit_err_flat
);

   state_t state, state_nxt;

   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] accepted;
   logic             run_start;
   logic             xfer;
   logic             last_xfer;

   logic             s1_valid;
   logic [OUT_W-1:0] s1_diff;
   logic [HD_W-1:0]  s1_hd;

   logic [CNT_W-1:0] bit_cnt [OUT_W];

   assign xfer      = pair_if.in_valid && pair_if.in_ready;
   assign last_xfer = xfer && (CNT_W'(accepted + CNT_W'(1)) == target);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
         RUN:        if (last_xfer) state_nxt = DRAIN;
         // stage 1 empties one edge after the last accept; stage 2 retires on that edge
         DRAIN:      if (!s1_valid) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pair_if.in_ready = (state == RUN) && (accepted < target);
      busy             = (state == RUN) || (state == DRAIN);
      done             = (state == DONE);
      run_start        = start && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_diff  <= '0;
         s1_hd    <= '0;
      end else begin
         s1_valid <= xfer;
         if (xfer) begin
            s1_diff <= pair_if.exact_po ^ pair_if.approx_po;
            s1_hd   <= HD_W'(f_popcount(wide_t'(pair_if.exact_po ^ pair_if.approx_po), OUT_W));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target      <= '0;
         accepted    <= '0;
         hd_sum      <= '0;
         err_samples <= '0;
         max_hd      <= '0;
      end else if (run_start) begin
         target      <= num_samples;
         accepted    <= '0;
         hd_sum      <= '0;
         err_samples <= '0;
         max_hd      <= '0;
      end else begin
         if (xfer) accepted <= CNT_W'(f_sat_inc(wide_t'(accepted), CNT_W));
         if (s1_valid) begin
            hd_sum <= hd_sum + ACC_W'(s1_hd);
            if (s1_hd != '0) err_samples <= CNT_W'(f_sat_inc(wide_t'(err_samples), CNT_W));
            if (s1_hd > max_hd) max_hd <= s1_hd;
         end
      end
   end

   for (genvar i = 0; i < OUT_W; i++) begin : g_bit
      mhd_bit_counter #(.CNT_W(CNT_W)) u_bit_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (run_start),
         .en    (s1_valid && s1_diff[i]),
         .count (bit_cnt[i])
      );
   end

   always_comb begin
      bit_err_flat = '0;
      for (int unsigned i = 0; i < OUT_W; i++) begin
         bit_err_flat[i*CNT_W +: CNT_W] = bit_cnt[i];
      end
   end

endmodule

// File: tb/tb_mhd_error_monitor.sv
// Scoreboard bench for mhd_error_monitor: run results are predicted when
// stimulus is prepared and compared when done rises.
module tb_mhd_error_monitor;

   typedef struct {
      logic [18:0] hd_sum;
      logic [15:0] err;
      logic [2:0]  max;
      logic [79:0] bits;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] num_samples = '0;
   logic        busy, done;
   logic [18:0] hd_sum;
   logic [15:0] err_samples;
   logic [2:0]  max_hd;
   logic [79:0] bit_err_flat;

   logic        start4 = 1'b0;
   logic [3:0]  num_samples4 = '0;
   logic        busy4, done4;
   logic [6:0]  hd_sum4;
   logic [3:0]  err_samples4;
   logic [2:0]  max_hd4;
   logic [19:0] bit_err_flat4;

   int checks = 0;
   int errors = 0;

   exp_t        exp_q[$];
   exp_t        last_exp;
   logic        done_q = 1'b0;
   logic [4:0]  ex_v [16];
   logic [4:0]  ap_v [16];

   mhd_error_monitor_if #(.OUT_W(5)) pif ();
   mhd_error_monitor_if #(.OUT_W(5)) pif4 ();

   mhd_error_monitor #(.OUT_W(5), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .pair_if(pif), .busy(busy), .done(done), .hd_sum(hd_sum),
      .err_samples(err_samples), .max_hd(max_hd), .bit_err_flat(bit_err_flat)
   );

   mhd_error_monitor #(.OUT_W(5), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .num_samples(num_samples4),
      .pair_if(pif4), .busy(busy4), .done(done4), .hd_sum(hd_sum4),
      .err_samples(err_samples4), .max_hd(max_hd4), .bit_err_flat(bit_err_flat4)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int n);
      exp_t e;
      logic [4:0] d;
      e.hd_sum = '0; e.err = '0; e.max = '0; e.bits = '0;
      for (int s = 0; s < n; s++) begin
         d = ex_v[s] ^ ap_v[s];
         e.hd_sum = e.hd_sum + 19'($countones(d));
         if (d != 5'd0) e.err = e.err + 16'd1;
         if (3'($countones(d)) > e.max) e.max = 3'($countones(d));
         for (int b = 0; b < 5; b++)
            if (d[b]) e.bits[b*16 +: 16] = e.bits[b*16 +: 16] + 16'd1;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (done && !done_q) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_done", 1, 0);
         end else begin
            last_exp = exp_q.pop_front();
            check_eq("sb_hd_sum", hd_sum, last_exp.hd_sum);
            check_eq("sb_err_samples", err_samples, last_exp.err);
            check_eq("sb_max_hd", max_hd, last_exp.max);
            check_eq("sb_bit_err", bit_err_flat, last_exp.bits);
         end
      end
      done_q = done;
   end

   task automatic check_idle_zero(input string tag);
      check_eq({tag, "_ready"}, pif.in_ready, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_hd_sum"}, hd_sum, 0);
      check_eq({tag, "_err"}, err_samples, 0);
      check_eq({tag, "_max"}, max_hd, 0);
      check_eq({tag, "_bits"}, bit_err_flat, 0);
   endtask

   task automatic run_case(input string name, input int n, input bit rand_v, input int extra,
                           input int start_idx, input int abort_idx);
      int  idx = 0;
      int  guard = 0;
      int  kmax;
      bit  v;
      if (abort_idx < 0) exp_q.push_back(model(n));
      @(negedge clk);
      num_samples = 16'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (n == 0) begin
         check_eq({name, "_n0_done"}, done, 1);
         check_eq({name, "_n0_busy"}, busy, 0);
         for (int k = 0; k < 3; k++) begin
            check_eq({name, "_n0_ready"}, pif.in_ready, 0);
            @(negedge clk);
         end
         return;
      end
      check_eq({name, "_clr_hd"}, hd_sum, 0);
      check_eq({name, "_clr_err"}, err_samples, 0);
      check_eq({name, "_clr_max"}, max_hd, 0);
      check_eq({name, "_clr_bits"}, bit_err_flat, 0);
      check_eq({name, "_run_done"}, done, 0);
      check_eq({name, "_run_busy"}, busy, 1);
      while (idx < n && guard < 200) begin
         if (idx == abort_idx) begin
            pif.in_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            check_idle_zero({name, "_abort"});
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_eq({name, "_abort_done"}, done, 0);
            check_eq({name, "_abort_busy"}, busy, 0);
            return;
         end
         v = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
         pif.in_valid  = v;
         pif.exact_po  = ex_v[idx];
         pif.approx_po = ap_v[idx];
         start         = (idx == start_idx);
         num_samples   = start ? 16'(n + 3) : 16'(n);
         if (v && pif.in_ready) idx++;
         guard++;
         @(negedge clk);
      end
      start = 1'b0;
      num_samples = 16'(n);
      check_eq({name, "_accepted"}, 32'(idx), 32'(n));
      kmax = (extra > 3) ? extra : 3;
      for (int k = 1; k <= kmax; k++) begin
         if (k > 1) @(negedge clk);
         check_eq({name, "_no_ready"}, pif.in_ready, 0);
         check_eq({name, "_latency_done"}, done, (k >= 3) ? 1 : 0);
         pif.in_valid  = (k <= extra);
         pif.exact_po  = 5'($urandom);
         pif.approx_po = 5'($urandom);
      end
      pif.in_valid = 1'b0;
   endtask

   initial begin
      int guard4;
      int acc4;
      pif.in_valid = 1'b0; pif.exact_po = '0; pif.approx_po = '0;
      pif4.in_valid = 1'b0; pif4.exact_po = '0; pif4.approx_po = '0;

      // reset state
      @(negedge clk);
      check_idle_zero("reset");
      check_eq("reset4_bits", bit_err_flat4, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // zero-sample run completes immediately with zero results
      run_case("t2", 0, 1'b0, 0, -1, -1);

      // directed four-sample run
      ex_v[0] = 5'b00000; ap_v[0] = 5'b00000;
      ex_v[1] = 5'b10101; ap_v[1] = 5'b10100;
      ex_v[2] = 5'b11111; ap_v[2] = 5'b00000;
      ex_v[3] = 5'b01010; ap_v[3] = 5'b01010;
      run_case("t1", 4, 1'b0, 0, -1, -1);
      check_eq("t1_hd_sum_const", hd_sum, 6);
      check_eq("t1_max_const", max_hd, 5);
      check_eq("t1_bit0_const", bit_err_flat[15:0], 2);
      check_eq("t1_bit4_const", bit_err_flat[79:64], 1);
      for (int k = 0; k < 4; k++) begin
         pif.in_valid = 1'b1;
         pif.exact_po = 5'b11111; pif.approx_po = 5'b00000;
         @(negedge clk);
         check_eq("t1_hold_hd_sum", hd_sum, last_exp.hd_sum);
         check_eq("t1_hold_bits", bit_err_flat, last_exp.bits);
         check_eq("t1_hold_done", done, 1);
      end
      pif.in_valid = 1'b0;

      // random valid gaps plus extra beats after the last accept
      for (int i = 0; i < 16; i++) begin
         ex_v[i] = 5'($urandom);
         ap_v[i] = 5'($urandom);
      end
      run_case("t3", 3, 1'b1, 5, -1, -1);

      // start pulses in RUN and together with the last transfer
      for (int i = 0; i < 16; i++) begin
         ex_v[i] = 5'($urandom);
         ap_v[i] = 5'($urandom);
      end
      run_case("t6a", 5, 1'b0, 0, 1, -1);
      run_case("t6b", 4, 1'b0, 0, 3, -1);

      // reset mid-run, then a fresh one-sample run
      run_case("t5", 8, 1'b0, 0, -1, 2);
      ex_v[0] = 5'b00011; ap_v[0] = 5'b00000;
      run_case("t5b", 1, 1'b0, 0, -1, -1);
      check_eq("t5b_hd_sum_const", hd_sum, 2);

      // narrow counters: preload bit0 near all-ones, then 15 differing samples
      @(negedge clk);
      num_samples4 = 4'd15;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      force u_dut4.g_bit[0].u_bit_cnt.count = 4'd12;
      @(negedge clk);
      release u_dut4.g_bit[0].u_bit_cnt.count;
      check_eq("t4_preload", bit_err_flat4[3:0], 12);
      acc4 = 0;
      guard4 = 0;
      pif4.exact_po = 5'b00001;
      pif4.approx_po = 5'b00000;
      while (acc4 < 15 && guard4 < 100) begin
         pif4.in_valid = 1'b1;
         if (pif4.in_ready) acc4++;
         guard4++;
         @(negedge clk);
      end
      pif4.in_valid = 1'b0;
      check_eq("t4_accepted", 32'(acc4), 15);
      @(negedge clk);
      @(negedge clk);
      check_eq("t4_done", done4, 1);
      check_eq("t4_bit0_sat", bit_err_flat4[3:0], 15);
      check_eq("t4_bits_hi", bit_err_flat4[19:4], 0);
      check_eq("t4_err_samples", err_samples4, 15);
      check_eq("t4_hd_sum", hd_sum4, 15);
      check_eq("t4_max_hd", max_hd4, 1);

      repeat (2) @(negedge clk);
      check_eq("sb_empty", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
